// File: rtl/match_engine_if.sv
// match_engine_if: deck load, card selection and game-status bundle between the
// keyboard/cursor path (master) and the match_engine core (slave).
interface match_engine_if #(
  parameter int N     = 16,
  parameter int SYM_W = 3,
  parameter int CNT_W = 4,
  parameter int IDX_W = $clog2(N)
);
  logic                 deck_load;
  logic [N*SYM_W-1:0]   deck;
  logic                 sel_valid;
  logic [IDX_W-1:0]     sel_idx;
  logic [N-1:0]         face_up;
  logic [N-1:0]         matched;
  logic [CNT_W-1:0]     ccount;
  logic [CNT_W-1:0]     wcount;
  logic                 pair_event;
  logic                 pair_match;
  logic                 busy;
  logic                 game_end;

  modport master (
    output deck_load, deck, sel_valid, sel_idx,
    input  face_up, matched, ccount, wcount, pair_event, pair_match, busy, game_end
  );

  modport slave (
    input  deck_load, deck, sel_valid, sel_idx,
    output face_up, matched, ccount, wcount, pair_event, pair_match, busy, game_end
  );
endinterface

// File: rtl/match_engine.sv
// match_engine: COLS x ROWS memory-game core - pair selection, compare, mismatch hold, scores.
// Define MATCH_PEEK_EN to build the opening full-deck reveal (PEEK state and timer).
module match_engine #(
  parameter int COLS        = 4,
  parameter int ROWS        = 4,
  parameter int SYM_W       = 3,
  parameter int CNT_W       = 4,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int PEEK_CYCLES = 50_000_000
) (
  input logic           clk,
  input logic           reset,
  match_engine_if.slave bus
);
  localparam int N      = COLS * ROWS;
  localparam int IDX_W  = $clog2(N);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [IDX_W:0]    N_L       = (IDX_W + 1)'(N);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [N-1:0]      ALL_ONES  = {N{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  if ((N < 2) || ((N % 2) != 0) || (HOLD_CYCLES < 1) || (PEEK_CYCLES < 1)) begin : g_bad_params
    $error("match_engine: illegal parameter set");
  end

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    PICK1   = 3'd1,
    PICK2   = 3'd2,
    COMPARE = 3'd3,
    HOLD    = 3'd4,
    DONE    = 3'd5
`ifdef MATCH_PEEK_EN
    , PEEK  = 3'd6
`endif
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [N*SYM_W-1:0]   deck_r, deck_nxt_s;
  logic [N-1:0]         face_up_r, face_nxt_s;
  logic [N-1:0]         matched_r, matched_nxt_s;
  logic [CNT_W-1:0]     ccount_r, ccount_nxt_s;
  logic [CNT_W-1:0]     wcount_r, wcount_nxt_s;
  logic                 pev_r, pev_nxt_s;
  logic                 pm_r, pm_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 end_r, end_nxt_s;
  logic [IDX_W-1:0]     first_r, first_nxt_s;
  logic [IDX_W-1:0]     second_r, second_nxt_s;
  logic [HOLD_W-1:0]    hold_r, hold_nxt_s;
  logic                 sel_ok_s;
  logic [SYM_W-1:0]     sym_s [N];
`ifdef MATCH_PEEK_EN
  localparam int PEEK_W = (PEEK_CYCLES > 1) ? $clog2(PEEK_CYCLES) : 1;
  localparam logic [PEEK_W-1:0] PEEK_LOAD = PEEK_W'(PEEK_CYCLES - 1);
  logic [PEEK_W-1:0]    peek_r, peek_nxt_s;
`endif

  // Unpack the registered deck into per-card symbols.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sym_s[i] = deck_r[i*SYM_W +: SYM_W];
    end
  end

  // Next-state and next-output logic of the game FSM.
  always_comb begin
    state_nxt_s   = state_r;
    deck_nxt_s    = deck_r;
    face_nxt_s    = face_up_r;
    matched_nxt_s = matched_r;
    ccount_nxt_s  = ccount_r;
    wcount_nxt_s  = wcount_r;
    pev_nxt_s     = 1'b0;
    pm_nxt_s      = pm_r;
    first_nxt_s   = first_r;
    second_nxt_s  = second_r;
    hold_nxt_s    = hold_r;
`ifdef MATCH_PEEK_EN
    peek_nxt_s    = peek_r;
`endif
    // The range test comes first so an out-of-range index never reaches the bit selects.
    sel_ok_s = bus.sel_valid && ({1'b0, bus.sel_idx} < N_L) &&
               !matched_r[bus.sel_idx] && !face_up_r[bus.sel_idx];

    if (bus.deck_load) begin
      deck_nxt_s    = bus.deck;
      face_nxt_s    = {N{1'b0}};
      matched_nxt_s = {N{1'b0}};
      ccount_nxt_s  = {CNT_W{1'b0}};
      wcount_nxt_s  = {CNT_W{1'b0}};
      pm_nxt_s      = 1'b0;
      hold_nxt_s    = {HOLD_W{1'b0}};
`ifdef MATCH_PEEK_EN
      face_nxt_s    = ALL_ONES;
      peek_nxt_s    = PEEK_LOAD;
      state_nxt_s   = PEEK;
`else
      state_nxt_s   = PICK1;
`endif
    end else begin
      case (state_r)
        EMPTY: state_nxt_s = EMPTY;
        PICK1: begin
          if (sel_ok_s) begin
            face_nxt_s[bus.sel_idx] = 1'b1;
            first_nxt_s             = bus.sel_idx;
            state_nxt_s             = PICK2;
          end else begin
            state_nxt_s = PICK1;
          end
        end
        PICK2: begin
          if (sel_ok_s) begin
            face_nxt_s[bus.sel_idx] = 1'b1;
            second_nxt_s            = bus.sel_idx;
            state_nxt_s             = COMPARE;
          end else begin
            state_nxt_s = PICK2;
          end
        end
        COMPARE: begin
          pev_nxt_s = 1'b1;
          if (sym_s[first_r] == sym_s[second_r]) begin
            pm_nxt_s                = 1'b1;
            matched_nxt_s[first_r]  = 1'b1;
            matched_nxt_s[second_r] = 1'b1;
            if (ccount_r != CNT_MAX) begin
              ccount_nxt_s = ccount_r + CNT_W'(1);
            end else begin
              ccount_nxt_s = ccount_r;
            end
            if (matched_nxt_s == ALL_ONES) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = PICK1;
            end
          end else begin
            pm_nxt_s   = 1'b0;
            hold_nxt_s = HOLD_LOAD;
            if (wcount_r != CNT_MAX) begin
              wcount_nxt_s = wcount_r + CNT_W'(1);
            end else begin
              wcount_nxt_s = wcount_r;
            end
            state_nxt_s = HOLD;
          end
        end
        HOLD: begin
          if (hold_r == {HOLD_W{1'b0}}) begin
            face_nxt_s[first_r]  = 1'b0;
            face_nxt_s[second_r] = 1'b0;
            state_nxt_s          = PICK1;
          end else begin
            hold_nxt_s = hold_r - HOLD_W'(1);
          end
        end
`ifdef MATCH_PEEK_EN
        PEEK: begin
          if (peek_r == {PEEK_W{1'b0}}) begin
            face_nxt_s  = {N{1'b0}};
            state_nxt_s = PICK1;
          end else begin
            peek_nxt_s = peek_r - PEEK_W'(1);
          end
        end
`endif
        DONE:    state_nxt_s = DONE;
        default: state_nxt_s = EMPTY;
      endcase
    end

    busy_nxt_s = (state_nxt_s == COMPARE) || (state_nxt_s == HOLD)
`ifdef MATCH_PEEK_EN
                 || (state_nxt_s == PEEK)
`endif
                 ;
    end_nxt_s  = (state_nxt_s == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= EMPTY;
      deck_r    <= {(N*SYM_W){1'b0}};
      face_up_r <= {N{1'b0}};
      matched_r <= {N{1'b0}};
      ccount_r  <= {CNT_W{1'b0}};
      wcount_r  <= {CNT_W{1'b0}};
      pev_r     <= 1'b0;
      pm_r      <= 1'b0;
      busy_r    <= 1'b0;
      end_r     <= 1'b0;
      first_r   <= {IDX_W{1'b0}};
      second_r  <= {IDX_W{1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
`ifdef MATCH_PEEK_EN
      peek_r    <= {PEEK_W{1'b0}};
`endif
    end else begin
      state_r   <= state_nxt_s;
      deck_r    <= deck_nxt_s;
      face_up_r <= face_nxt_s;
      matched_r <= matched_nxt_s;
      ccount_r  <= ccount_nxt_s;
      wcount_r  <= wcount_nxt_s;
      pev_r     <= pev_nxt_s;
      pm_r      <= pm_nxt_s;
      busy_r    <= busy_nxt_s;
      end_r     <= end_nxt_s;
      first_r   <= first_nxt_s;
      second_r  <= second_nxt_s;
      hold_r    <= hold_nxt_s;
`ifdef MATCH_PEEK_EN
      peek_r    <= peek_nxt_s;
`endif
    end
  end

  assign bus.face_up    = face_up_r;
  assign bus.matched    = matched_r;
  assign bus.ccount     = ccount_r;
  assign bus.wcount     = wcount_r;
  assign bus.pair_event = pev_r;
  assign bus.pair_match = pm_r;
  assign bus.busy       = busy_r;
  assign bus.game_end   = end_r;
endmodule

// File: tb/tb_match_engine.sv
// Self-checking bench for match_engine: 2x2 grid vector table, pair-result scoreboard,
// hand sequences for saturation, reset-in-HOLD, out-of-range select and (optionally) peek.
module tb_match_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  match_engine_if #(.N(4), .SYM_W(2), .CNT_W(2)) bus ();
  match_engine_if #(.N(6), .SYM_W(2), .CNT_W(2)) bus6 ();

  match_engine #(.COLS(2), .ROWS(2), .SYM_W(2), .CNT_W(2), .HOLD_CYCLES(4), .PEEK_CYCLES(3))
    dut (.clk(clk), .reset(reset), .bus(bus));
  match_engine #(.COLS(3), .ROWS(2), .SYM_W(2), .CNT_W(2), .HOLD_CYCLES(4), .PEEK_CYCLES(3))
    dut6 (.clk(clk), .reset(reset), .bus(bus6));

  typedef struct {
    string      name;
    logic       ld;
    logic       sv;
    logic [1:0] idx;
    logic       judge;
    logic       jm;
    logic [3:0] face;
    logic [3:0] mat;
    logic [1:0] cc;
    logic [1:0] wc;
    logic       pev;
    logic       busy;
    logic       gend;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic sv, input logic [1:0] idx);
    bus.deck_load = ld;
    bus.sel_valid = sv;
    bus.sel_idx   = idx;
    @(negedge clk);
    bus.deck_load = 1'b0;
    bus.sel_valid = 1'b0;
  endtask

  task automatic step6(input logic ld, input logic sv, input logic [2:0] idx);
    bus6.deck_load = ld;
    bus6.sel_valid = sv;
    bus6.sel_idx   = idx;
    @(negedge clk);
    bus6.deck_load = 1'b0;
    bus6.sel_valid = 1'b0;
  endtask

  task automatic do_load();
    step(1'b1, 1'b0, 2'd0);
`ifdef MATCH_PEEK_EN
    repeat (3) step(1'b0, 1'b0, 2'd0);
`endif
  endtask

  // Scoreboard: every pair_event must match the next queued judgement.
  always @(negedge clk) begin
    if (bus.pair_event) begin
      if (sb_q.size() == 0) begin
        check("pair_event_unexpected", 32'd1, 32'd0);
      end else begin
        check("pair_match", {31'd0, bus.pair_match}, {31'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.deck_load  = 1'b0;  bus.sel_valid  = 1'b0;  bus.sel_idx  = 2'd0;
    bus.deck       = {2'd1, 2'd0, 2'd1, 2'd0};
    bus6.deck_load = 1'b0;  bus6.sel_valid = 1'b0;  bus6.sel_idx = 3'd0;
    bus6.deck      = {2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};

    //            name         ld    sv    idx   jdg   jm    face   mat    cc    wc    pev   busy  end
    tbl[0]  = '{"load",        1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{"sel1",        1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h2, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{"resel1",      1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h2, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{"sel2_cmp",    1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 4'h6, 4'h0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{"miss_judge",  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h6, 4'h0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{"hold_sel0",   1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h6, 4'h0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{"hold2",       1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h6, 4'h0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{"hold3",       1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h6, 4'h0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{"hold_clear",  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{"sel0",        1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h1, 4'h0, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{"sel2_cmp",    1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 4'h5, 4'h0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{"hit_judge",   1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'h5, 4'h5, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{"sel_matched", 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'h5, 4'h5, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{"sel1b",       1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h7, 4'h5, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{"sel3_cmp",    1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 4'hF, 4'h5, 2'd1, 2'd1, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{"done",        1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'hF, 4'hF, 2'd2, 2'd1, 1'b1, 1'b0, 1'b1};
    tbl[16] = '{"done_sel",    1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 4'hF, 4'hF, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{"load_and_sel",1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{"pick1_again", 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 4'h2, 4'h0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_state", {bus.face_up, bus.matched, bus.ccount, bus.wcount, bus.pair_event,
                          bus.pair_match, bus.busy, bus.game_end}, 32'd0);
    reset = 1'b0;

`ifndef MATCH_PEEK_EN
    for (int i = 0; i < 19; i++) begin
      if (tbl[i].judge) sb_q.push_back(tbl[i].jm);
      step(tbl[i].ld, tbl[i].sv, tbl[i].idx);
      check(tbl[i].name,
            {17'd0, bus.face_up, bus.matched, bus.ccount, bus.wcount, bus.pair_event, bus.busy, bus.game_end},
            {17'd0, tbl[i].face, tbl[i].mat, tbl[i].cc, tbl[i].wc, tbl[i].pev, tbl[i].busy, tbl[i].gend});
    end
`else
    // Opening reveal: all cards up and busy for three cycles, selections ignored.
    step(1'b1, 1'b1, 2'd0);
    check("peek_c1", {bus.face_up, bus.busy}, {4'hF, 1'b1});
    step(1'b0, 1'b1, 2'd0);
    check("peek_c2", {bus.face_up, bus.busy}, {4'hF, 1'b1});
    step(1'b0, 1'b1, 2'd1);
    check("peek_c3", {bus.face_up, bus.busy}, {4'hF, 1'b1});
    step(1'b0, 1'b1, 2'd2);
    check("peek_end", {bus.face_up, bus.busy}, {4'h0, 1'b0});
    step(1'b0, 1'b1, 2'd0);
    check("peek_pick1", {bus.face_up, bus.busy}, {4'h1, 1'b0});
`endif

    // Five mismatches saturate the 2-bit wrong counter at 3.
    do_load();
    for (int m = 0; m < 5; m++) begin
      step(1'b0, 1'b1, 2'd1);
      sb_q.push_back(1'b0);
      step(1'b0, 1'b1, 2'd2);
      repeat (5) step(1'b0, 1'b0, 2'd0);
      if (m == 2) check("wcount_3", {30'd0, bus.wcount}, 32'd3);
    end
    check("wcount_sat", {bus.ccount, bus.wcount, bus.face_up}, {2'd0, 2'd3, 4'h0});

    // Reset in the middle of HOLD aborts to EMPTY with all outputs cleared.
    do_load();
    step(1'b0, 1'b1, 2'd0);
    sb_q.push_back(1'b0);
    step(1'b0, 1'b1, 2'd3);
    step(1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 2'd0);
    check("in_hold", {bus.busy, bus.wcount, bus.face_up}, {1'b1, 2'd1, 4'h9});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_in_hold", {bus.face_up, bus.matched, bus.ccount, bus.wcount, bus.pair_event,
                            bus.pair_match, bus.busy, bus.game_end}, 32'd0);
    step(1'b0, 1'b1, 2'd0);
    check("empty_ignores_sel", {28'd0, bus.face_up}, 32'd0);

    // Out-of-range indices on a 6-card grid are ignored; a legal one still works.
    step6(1'b1, 1'b0, 3'd0);
`ifdef MATCH_PEEK_EN
    repeat (3) step6(1'b0, 1'b0, 3'd0);
`endif
    step6(1'b0, 1'b1, 3'd7);
    check("idx7_ignored", {26'd0, bus6.face_up}, 32'd0);
    step6(1'b0, 1'b1, 3'd6);
    check("idx6_ignored", {26'd0, bus6.face_up}, 32'd0);
    step6(1'b0, 1'b1, 3'd5);
    check("idx5_accepted", {26'd0, bus6.face_up}, 32'h20);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
